// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palette_pkg
// Description : Shared opcodes, command field positions and FSM state
//               encoding for the palette command controller.
// Revision    : 1.0 - initial release
// ============================================================================
package palette_pkg;

    // Palette opcodes carried in the command word; every other value is a NOP
    localparam logic [4:0] OP_WRITE = 5'b10011;
    localparam logic [4:0] OP_CLEAR = 5'b11100;

    // Command word field positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 11;
    localparam int HALF_BIT  = 10;  // 0 = RG half, 1 = BX half

    // Payload word channel positions (MSB of each channel, CHAN_W wide)
    localparam int CHAN0_MSB = 15;
    localparam int CHAN1_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CLEAR = 2'd2
    } palState_t;

endpackage : palette_pkg
`default_nettype wire

// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
// Module      : palette_ram
// Description : Simple dual-port palette storage. One write port with
//               separate enables for the RG part and the B part of an entry,
//               one synchronous read port (read-before-write on collision).
//               The storage array is not reset; only the read register is.
// Ports       : clk, rst_n    - clock, synchronous active-low reset
//               i_weRG, i_weB - write enables for {R,G} and {B}
//               i_wrAddr      - write slot
//               i_wrData      - {R,G,B} write data
//               i_rdEn        - read request
//               i_rdAddr      - read slot
//               o_rdData      - registered {R,G,B}, held while i_rdEn=0
// Revision    : 1.0 - initial release
// ============================================================================
module palette_ram #(
    parameter int DEPTH  = 16,
    parameter int CHAN_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_weRG,
    input  logic                  i_weB,
    input  logic [ADDR_W-1:0]     i_wrAddr,
    input  logic [3*CHAN_W-1:0]   i_wrData,
    input  logic                  i_rdEn,
    input  logic [ADDR_W-1:0]     i_rdAddr,
    output logic [3*CHAN_W-1:0]   o_rdData
);

    logic [3*CHAN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_weRG) begin
            r_mem[i_wrAddr][3*CHAN_W-1:CHAN_W] <= i_wrData[3*CHAN_W-1:CHAN_W];
        end
        if (i_weB) begin
            r_mem[i_wrAddr][CHAN_W-1:0] <= i_wrData[CHAN_W-1:0];
        end
    end

    // Non-blocking read sees the pre-edge contents, giving read-before-write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rdData <= '0;
        end else if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule : palette_ram
`default_nettype wire

// File: rtl/palette_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : palette_cmd_ctrl
// Description : Palette controller on the GPU command path. Decodes 16-bit
//               commands (valid/ready), performs two-beat half-entry writes,
//               a SLOTS-cycle clear sweep (also after every reset) and serves
//               a one-cycle-latency colour lookup port.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               cmd_valid/cmd_data  - command or payload word
//               cmd_ready           - word accepted this cycle when valid
//               busy                - clear sweep in progress
//               rd_en/rd_slot       - lookup request and index
//               rd_valid/rd_rgb     - registered lookup result {R,G,B}
// Revision    : 1.0 - initial release
// ============================================================================
module palette_cmd_ctrl
    import palette_pkg::*;
#(
    parameter int SLOTS  = 16,
    parameter int CHAN_W = 8,
    parameter int SLOT_W = $clog2(SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [15:0]           cmd_data,
    output logic                  cmd_ready,
    output logic                  busy,
    input  logic                  rd_en,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic                  rd_valid,
    output logic [3*CHAN_W-1:0]   rd_rgb
);

    localparam logic [SLOT_W-1:0] c_lastSlot = SLOT_W'(SLOTS - 1);

    palState_t             r_state;
    palState_t             w_nextState;
    logic [SLOT_W-1:0]     r_slot;
    logic                  r_half;
    logic [SLOT_W-1:0]     r_clrPtr;
    logic                  w_latch;
    logic                  w_weRG;
    logic                  w_weB;
    logic [SLOT_W-1:0]     w_wrAddr;
    logic [3*CHAN_W-1:0]   w_wrData;
    logic [4:0]            w_opcode;

    assign w_opcode = cmd_data[OPC_MSB:OPC_LSB];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_CLEAR;
            r_clrPtr <= '0;
            r_slot   <= '0;
            r_half   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            rd_valid <= rd_en;
            if (w_latch) begin
                r_slot <= cmd_data[SLOT_W-1:0];
                r_half <= cmd_data[HALF_BIT];
            end
            if (r_state == ST_CLEAR) begin
                r_clrPtr <= r_clrPtr + 1'b1;
            end else begin
                r_clrPtr <= '0;
            end
        end
    end

    // Payload layout matches the entry layout: first channel lands in R and
    // in B, second in G, so the half enables alone pick what is stored.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_weRG      = 1'b0;
        w_weB       = 1'b0;
        w_wrAddr    = r_slot;
        w_wrData    = {cmd_data[CHAN0_MSB -: CHAN_W],
                       cmd_data[CHAN1_MSB -: CHAN_W],
                       cmd_data[CHAN0_MSB -: CHAN_W]};
        cmd_ready   = 1'b0;
        busy        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_opcode == OP_WRITE) begin
                        w_latch     = 1'b1;
                        w_nextState = ST_DATA;
                    end else if (w_opcode == OP_CLEAR) begin
                        w_nextState = ST_CLEAR;
                    end
                end
            end
            ST_DATA: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_weRG      = ~r_half;
                    w_weB       = r_half;
                    w_nextState = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                w_weRG   = 1'b1;
                w_weB    = 1'b1;
                w_wrAddr = r_clrPtr;
                w_wrData = '0;
                if (r_clrPtr == c_lastSlot) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_CLEAR;
            end
        endcase

        // While reset is asserted nothing is accepted and a pending payload
        // write must not land in the RAM.
        if (!rst_n) begin
            cmd_ready = 1'b0;
            busy      = 1'b1;
            w_latch   = 1'b0;
            w_weRG    = 1'b0;
            w_weB     = 1'b0;
        end
    end

    palette_ram #(
        .DEPTH  (SLOTS),
        .CHAN_W (CHAN_W),
        .ADDR_W (SLOT_W)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_weRG   (w_weRG),
        .i_weB    (w_weB),
        .i_wrAddr (w_wrAddr),
        .i_wrData (w_wrData),
        .i_rdEn   (rd_en),
        .i_rdAddr (rd_slot),
        .o_rdData (rd_rgb)
    );

endmodule : palette_cmd_ctrl
`default_nettype wire

// File: tb/tb_palette_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_palette_cmd_ctrl
// Description : Directed self-checking bench for palette_cmd_ctrl
//               (SLOTS=16, CHAN_W=8). Inputs change 1 ns after the rising
//               edge; outputs are sampled on the falling edge or 1 ns after
//               the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        busy;
    logic        rd_en;
    logic [3:0]  rd_slot;
    logic        rd_valid;
    logic [23:0] rd_rgb;

    int checkCnt = 0;
    int errCnt   = 0;

    // Reference palette and command-sequence tracking
    logic [23:0] model [16];
    logic        tbInData;
    logic        tbHalf;
    logic [3:0]  tbSlot;

    palette_cmd_ctrl #(
        .SLOTS  (16),
        .CHAN_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_slot   (rd_slot),
        .rd_valid  (rd_valid),
        .rd_rgb    (rd_rgb)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 16; i++) model[i] = 24'h0;
        tbInData = 1'b0;
    endtask

    // Reference behaviour of one accepted word
    task automatic applyWord(input logic [15:0] w);
        if (tbInData) begin
            if (tbHalf) model[tbSlot][7:0]  = w[15:8];
            else        model[tbSlot][23:8] = w;
            tbInData = 1'b0;
        end else if (w[15:11] == 5'b10011) begin
            tbInData = 1'b1;
            tbHalf   = w[10];
            tbSlot   = w[3:0];
        end else if (w[15:11] == 5'b11100) begin
            modelClear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic sendWord(input logic [15:0] w);
        int n;
        cmd_valid = 1'b1;
        cmd_data  = w;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkVal("sendReady", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0;
    endtask

    task automatic sendCmd(input logic [15:0] w);
        sendWord(w);
        applyWord(w);
    endtask

    // Called at posedge+1; result sampled 1 ns after the capturing edge
    task automatic readSlot(input logic [3:0] s, output logic [23:0] val);
        rd_en   = 1'b1;
        rd_slot = s;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        checkVal("rdValid", {31'b0, rd_valid}, 32'd1);
        val = rd_rgb;
    endtask

    task automatic checkAll(input string tag);
        logic [23:0] v;
        for (int i = 0; i < 16; i++) begin
            readSlot(4'(i), v);
            checkVal(tag, {8'h0, v}, {8'h0, model[i]});
        end
    endtask

    // Counts falling edges on which busy is high; called at posedge+1
    task automatic countBusy(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [23:0] v;
        int cnt;
        logic [15:0] bpWords [14];

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0;
        rd_en     = 1'b0;
        rd_slot   = 4'h0;
        tbHalf    = 1'b0;
        tbSlot    = 4'h0;
        modelClear();

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        checkVal("rstReady",   {31'b0, cmd_ready}, 32'd0);
        checkVal("rstBusy",    {31'b0, busy},      32'd1);
        checkVal("rstRdValid", {31'b0, rd_valid},  32'd0);
        checkVal("rstRdRgb",   {8'h0, rd_rgb},     32'h0);
        rst_n = 1'b1;
        countBusy(cnt);
        checkVal("rstBusyCycles", cnt, 32'd16);
        checkVal("rstReadyAfter", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkAll("rstSlot");

        // ---------------- full-entry write ----------------
        sendCmd(16'h9803);
        sendCmd(16'h1234);
        sendCmd(16'h9C03);
        sendCmd(16'h56FF);
        readSlot(4'd3, v);
        checkVal("fullEntry", {8'h0, v}, 32'h123456);
        @(posedge clk);
        #1;
        checkVal("rdValidDrop", {31'b0, rd_valid}, 32'd0);
        checkVal("rdRgbHold",   {8'h0, rd_rgb},    32'h123456);

        // ---------------- half writes ----------------
        sendCmd(16'h9805);
        sendCmd(16'hAABB);
        sendCmd(16'h9C05);
        sendCmd(16'hCC00);
        readSlot(4'd5, v);
        checkVal("halfBoth", {8'h0, v}, 32'hAABBCC);
        sendCmd(16'h9805);
        sendCmd(16'h0102);
        readSlot(4'd5, v);
        checkVal("halfRgOnly", {8'h0, v}, 32'h0102CC);

        // ---------------- read-before-write on the payload edge ----------------
        sendCmd(16'h9807);
        cmd_valid = 1'b1;
        cmd_data  = 16'h7788;
        rd_en     = 1'b1;
        rd_slot   = 4'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rd_en     = 1'b0;
        applyWord(16'h7788);
        checkVal("readBeforeWrite", {8'h0, rd_rgb}, 32'h0);
        readSlot(4'd7, v);
        checkVal("writeThenRead", {8'h0, v}, 32'h778800);

        // ---------------- clear with the next command held ----------------
        sendCmd(16'hE000);
        cmd_valid = 1'b1;
        cmd_data  = 16'h9802;
        cnt = 0;
        @(negedge clk);
        checkVal("clrBusy", {31'b0, busy}, 32'd1);
        while (!cmd_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checkVal("clrStallCycles", cnt, 32'd16);
        @(posedge clk);
        #1;
        applyWord(16'h9802);
        sendCmd(16'h0A0B);
        checkAll("clrSlot");

        // ---------------- backpressure, NOPs, ignored bits ----------------
        bpWords = '{16'h0000, 16'h9801, 16'h1122, 16'hD800, 16'h9C01, 16'h3300,
                    16'h9BF4, 16'h0000, 16'h9C04, 16'hE0FF, 16'h0000, 16'h980F,
                    16'hFEDC, 16'hD800};
        foreach (bpWords[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            sendCmd(bpWords[i]);
        end
        checkVal("payloadNoSweep", {31'b0, busy}, 32'd0);
        checkAll("bpSlot");

        // ---------------- reset during DATA ----------------
        sendCmd(16'h9806);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 16'h4455;
        @(negedge clk);
        checkVal("rstDataReady", {31'b0, cmd_ready}, 32'd0);
        checkVal("rstDataBusy",  {31'b0, busy},      32'd1);
        @(posedge clk);
        #1;
        checkVal("rstDataRgb", {8'h0, rd_rgb}, 32'h0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        modelClear();
        countBusy(cnt);
        checkVal("rstDataBusyCycles", cnt, 32'd16);
        @(posedge clk);
        #1;
        checkAll("rstDataSlot");

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_palette_cmd_ctrl
`default_nettype wire

// File: doc/palette_cmd_ctrl.md
# palette_cmd_ctrl

Parametrised palette controller for the GPU command path. It accepts 16-bit controller commands over a valid/ready handshake and decodes palette opcodes. It writes RGB entries into an internal palette RAM using a two-beat command+payload sequence, and clears the whole palette with a timed sweep. It also serves a 1-cycle-latency colour lookup port to the pixel pipeline.

## Interface
Parameters:
- `SLOTS`, 16: palette entries; 2..1024, power of two.
- `CHAN_W`, 8: bits per colour channel; 1..8.
- `SLOT_W`, $clog2(SLOTS): derived; not overridden.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `cmd_valid`  in  1  command/payload word valid.
- `cmd_data`  in  16  command or payload word.
- `cmd_ready`  out  1  block accepts `cmd_data` this cycle.
- `busy`  out  1  clear sweep in progress.
- `rd_en`  in  1  lookup request.
- `rd_slot`  in  SLOT_W  lookup index.
- `rd_valid`  out  1  `rd_rgb` valid; `rd_en` delayed one cycle.
- `rd_rgb`  out  3*CHAN_W  {R,G,B} of the looked-up slot.

## Operation
- Command fields:
  - opcode `cmd_data[15:11]`.
  - half select `cmd_data[10]`: 0 = RG, 1 = BX.
  - slot `cmd_data[SLOT_W-1:0]`. Bits [9:SLOT_W] are ignored.
- Opcodes:
  - `OP_WRITE` = 5'b10011.
  - `OP_CLEAR` = 5'b11100.
  - All other opcodes are NOP: accepted and ignored.
- Payload word:
  - first channel `cmd_data[15 -: CHAN_W]`.
  - second channel `cmd_data[7 -: CHAN_W]`.
  - For a BX write, only B is taken from the first channel; the second channel is ignored.
- FSM states: IDLE, DATA, CLEAR.
  - IDLE: `cmd_ready`=1.
    - Accepted `OP_WRITE`: latch slot and half, go to DATA.
    - Accepted `OP_CLEAR`: go to CLEAR with `clr_ptr`=0.
    - NOP: stay in IDLE.
  - DATA: `cmd_ready`=1. The next accepted word is payload regardless of its bits.
    - On acceptance, write the selected half of the latched slot and go to IDLE.
    - The other half of that slot is unchanged (per-half byte enables).
  - CLEAR: `cmd_ready`=0, `busy`=1.
    - Write zero to slot `clr_ptr`, then increment `clr_ptr`.
    - After the write to slot SLOTS-1, go to IDLE. The sweep lasts exactly SLOTS cycles.
- Reset: state goes to CLEAR with `clr_ptr`=0, so the palette is zeroed after every reset.
- Handshake:
  - A transfer happens only when `cmd_valid & cmd_ready` are both 1.
  - `cmd_data` is don't-care otherwise.
  - The upstream may hold `cmd_valid` high across `cmd_ready`=0 without loss.
- Lookup:
  - Serviced in every state, including CLEAR. During CLEAR, a read returns the current RAM content, which may be partially cleared.
  - Same-cycle write and read to one slot returns the old value (read-before-write).

## Timing
- Values while `rst_n`=0 and in the first cycle after release: `cmd_ready`=0, `busy`=1, `rd_valid`=0, `rd_rgb`=0.
- After reset release: `busy` stays 1 for SLOTS cycles, then `cmd_ready`=1.
- Write latency:
  - The payload write lands at the edge that accepts the payload.
  - A read issued in the following cycle returns the new value.
- Clear latency:
  - `OP_CLEAR` accepted at edge t: `busy`=1 during cycles t+1 .. t+SLOTS.
  - `cmd_ready` returns to 1 at t+SLOTS+1.
- Lookup latency: `rd_rgb` and `rd_valid` are registered, one cycle after `rd_en`.
  - `rd_rgb` holds its last value when `rd_valid`=0.
- Back-to-back commands: throughput is one word per cycle in IDLE/DATA, with no bubbles between consecutive WRITE pairs.
- Reset during DATA: the pending half-write is dropped and a clear sweep restarts from slot 0.

## Structure
- Package `palette_pkg`:
  - opcode constants `OP_WRITE`, `OP_CLEAR`.
  - FSM state enum.
  - field position constants (opcode, half, slot).
- Sub-module `palette_ram`:
  - simple dual-port, one write and one synchronous read port, depth SLOTS, width 3*CHAN_W.
  - write enables for the RG and B parts.
  - no reset on the storage array.
- Top level holds the FSM, slot/half latch, `clr_ptr` and the read-valid register.

## Test plan
- Reset:
  - Release `rst_n` with SLOTS=16 → `busy`=1 for exactly 16 cycles, `cmd_ready` rises on cycle 17.
  - Then read all slots → every slot returns 0.
- Full-entry write:
  - Send `cmd_data`=0x9803 (WRITE RG slot 3), then payload 0x1234.
  - Send 0x9C03 (WRITE BX slot 3), then payload 0x56FF.
  - Read slot 3 → `rd_rgb`=0x123456, one cycle after `rd_en`.
- Half write: write RG of slot 5 = 0xAABB, then BX of slot 5 = 0xCC00 → read gives 0xAABBCC. A later RG write of 0x0102 → read gives 0x0102CC.
- Clear mid-stream:
  - Issue `OP_CLEAR` (0xE000) while `cmd_valid` stays high with the next command.
  - Required: `cmd_ready`=0 for 16 cycles, the held command is accepted afterwards, all slots read 0.
- Backpressure and NOPs: randomly deassert `cmd_valid` and interleave NOP opcodes (0x0000, 0xD800) → palette contents match the reference model and no word is lost.
- Reset during DATA: `rst_n` low for one cycle after a WRITE command without payload → no slot is modified before the sweep, and a new 16-cycle clear runs.
